// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and the popcount helper for the register file scoreboard
// Contents: NREG_DEF/DBITS_DEF/NRD_DEF defaults, POP_MAX (largest supported NREG), popcount_f
package regfile_pkg;
    localparam int NREG_DEF  = 32;
    localparam int DBITS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int POP_MAX   = 1024;
    function automatic int popcount_f(input logic [POP_MAX-1:0] v);
        int n;
        n = 0;
        for (int k = 0; k < POP_MAX; k++) n += int'(v[k]);
        return n;
    endfunction
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with zero-register mux and optional write bypass
// Ports: addr (read address), stored/stored_busy (array contents at addr), wr_en/wr_addr/wr_data
//        and rsv_en/rsv_addr (same-cycle writeback and reservation), data/busy (port result)
// Config: REGFILE_BYPASS_EN forwards a same-cycle write to this port
module regfile_read_port #(
    parameter int DBITS = 32,
    parameter int ABITS = 5
) (
    input  logic [ABITS-1:0] addr,
    input  logic [DBITS-1:0] stored,
    input  logic             stored_busy,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [DBITS-1:0] wr_data,
    input  logic             rsv_en,
    input  logic [ABITS-1:0] rsv_addr,
    output logic [DBITS-1:0] data,
    output logic             busy
);
    wire zero = addr == '0;
`ifdef REGFILE_BYPASS_EN
    // A forwarded write retires the old reservation unless a younger one lands on the same edge.
    wire hit = wr_en && wr_addr == addr;
    assign data = zero ? '0 : hit ? wr_data : stored;
    assign busy = zero ? 1'b0 : hit ? (rsv_en && rsv_addr == addr) : stored_busy;
`else
    logic unused_byp;
    assign unused_byp = ^{wr_en, wr_addr, wr_data, rsv_en, rsv_addr};
    assign data = zero ? '0 : stored;
    assign busy = zero ? 1'b0 : stored_busy;
`endif
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with r0 hard-wired to zero and a busy scoreboard
// Ports: clock, reset (async active-high); rd_addr/rd_data/rd_busy (NRD packed read ports);
//        wr_en/wr_addr/wr_data (writeback); rsv_en/rsv_addr (reserve); busy_count (busy popcount)
// Config: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding in each read port
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int DBITS = DBITS_DEF,
    parameter int NRD   = NRD_DEF,
    parameter int ABITS = $clog2(NREG)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NRD*ABITS-1:0]       rd_addr,
    output logic [NRD*DBITS-1:0]       rd_data,
    output logic [NRD-1:0]             rd_busy,
    input  logic                       wr_en,
    input  logic [ABITS-1:0]           wr_addr,
    input  logic [DBITS-1:0]           wr_data,
    input  logic                       rsv_en,
    input  logic [ABITS-1:0]           rsv_addr,
    output logic [$clog2(NREG+1)-1:0]  busy_count
);
    localparam int CW = $clog2(NREG+1);
    logic [DBITS-1:0] regs [NREG];
    logic [NREG-1:0]  busy, busy_nxt;
    // Bypass is suppressed under reset so reads stay zero while reset is held.
    wire byp_wr = wr_en && !reset;
    always_comb begin
        busy_nxt = busy;
        if (wr_en && wr_addr != '0) busy_nxt[wr_addr] = 1'b0;
        if (rsv_en && rsv_addr != '0) busy_nxt[rsv_addr] = 1'b1;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
            busy       <= busy_nxt;
            busy_count <= CW'(popcount_f(POP_MAX'(busy_nxt)));
        end
    end
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        wire [ABITS-1:0] a = rd_addr[i*ABITS +: ABITS];
        regfile_read_port #(.DBITS(DBITS), .ABITS(ABITS)) u_port (
            .addr        (a),
            .stored      (regs[a]),
            .stored_busy (busy[a]),
            .wr_en       (byp_wr),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .rsv_en      (rsv_en),
            .rsv_addr    (rsv_addr),
            .data        (rd_data[i*DBITS +: DBITS]),
            .busy        (rd_busy[i])
        );
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks of regfile_scoreboard against an array model
module tb_regfile_scoreboard;
    localparam int NREG = 32, DBITS = 32, NRD = 2, ABITS = 5, CW = 6;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic                 clock = 1'b0;
    logic                 reset;
    logic [NRD*ABITS-1:0] rd_addr;
    logic [NRD*DBITS-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr_en, rsv_en;
    logic [ABITS-1:0]     wr_addr, rsv_addr;
    logic [DBITS-1:0]     wr_data;
    logic [CW-1:0]        busy_count;
    int errors = 0, checks = 0;
    logic [DBITS-1:0] m_data [NREG];
    bit               m_busy [NREG];

    regfile_scoreboard #(.NREG(NREG), .DBITS(DBITS), .NRD(NRD)) dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_count(busy_count)
    );

    always #5 clock = ~clock;

    function automatic logic [DBITS-1:0] exp_data(int a);
        if (a == 0) return '0;
        if (BYP && wr_en && int'(wr_addr) == a) return wr_data;
        return m_data[a];
    endfunction

    function automatic logic exp_busy(int a);
        if (a == 0) return 1'b0;
        if (BYP && wr_en && int'(wr_addr) == a) return rsv_en && int'(rsv_addr) == a;
        return m_busy[a];
    endfunction

    function automatic int exp_count();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            m_data[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {ABITS'(a1), ABITS'(a0)};
    endtask

    task automatic idle();
        wr_en = 0; rsv_en = 0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
    endtask

    // Advance one edge; the model absorbs the inputs present at that edge.
    task automatic cycle();
        @(posedge clock);
        if (wr_en && wr_addr != 0) begin
            m_data[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        #1;
        idle();
    endtask

    task automatic test_reset();
        reset = 1; idle(); set_rd(0, 0); model_clear();
        #3;
        for (int a = 0; a < NREG; a++) begin
            set_rd(a, NREG-1-a);
            #1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*DBITS +: DBITS] !== '0 || rd_busy[p] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_read a=%0d p=%0d: got data=%h busy=%b expected 0/0", a, p, rd_data[p*DBITS +: DBITS], rd_busy[p]);
                end
            end
        end
        checks++;
        if (busy_count !== '0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", busy_count);
        end
        @(negedge clock); reset = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; cycle();
        set_rd(5, 0); #1;
        checks++;
        if (rd_data[0 +: DBITS] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r5: got %h expected deadbeef", rd_data[0 +: DBITS]);
        end
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234; cycle();
        set_rd(0, 0); #1;
        checks++;
        if (rd_data[0 +: DBITS] !== '0 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_r0: got %h busy=%b expected 0/0", rd_data[0 +: DBITS], rd_busy[0]);
        end
    endtask

    task automatic test_reserve();
        rsv_en = 1; rsv_addr = 7; cycle();
        set_rd(7, 7); #1;
        checks++;
        if (rd_busy !== 2'b11 || busy_count !== 6'd1) begin
            errors++;
            $display("FAIL reserve_r7: got busy=%b count=%0d expected 11/1", rd_busy, busy_count);
        end
        wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5; cycle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[0 +: DBITS] !== 32'hA5A5 || busy_count !== 6'd0) begin
            errors++;
            $display("FAIL release_r7: got busy=%b data=%h count=%0d expected 0/a5a5/0", rd_busy[0], rd_data[0 +: DBITS], busy_count);
        end
    endtask

    task automatic test_write_reserve_same();
        wr_en = 1; wr_addr = 9; wr_data = 32'h11; rsv_en = 1; rsv_addr = 9; cycle();
        set_rd(9, 9); #1;
        checks++;
        if (rd_data[DBITS +: DBITS] !== 32'h11 || rd_busy[1] !== 1'b1 || busy_count !== 6'd1) begin
            errors++;
            $display("FAIL wr_rsv_r9: got data=%h busy=%b count=%0d expected 11/1/1", rd_data[DBITS +: DBITS], rd_busy[1], busy_count);
        end
        wr_en = 1; wr_addr = 9; wr_data = 32'h12; cycle();
    endtask

    task automatic test_bypass();
        logic [DBITS-1:0] exp;
        wr_en = 1; wr_addr = 3; wr_data = 32'h55; cycle();
        set_rd(0, 3);
        wr_en = 1; wr_addr = 3; wr_data = 32'h77;
        #1;
        exp = BYP ? 32'h77 : 32'h55;
        checks++;
        if (rd_data[DBITS +: DBITS] !== exp || rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_r3: got %h busy=%b expected %h/0", rd_data[DBITS +: DBITS], rd_busy[1], exp);
        end
        cycle();
        #1;
        checks++;
        if (rd_data[DBITS +: DBITS] !== 32'h77) begin
            errors++;
            $display("FAIL after_bypass_r3: got %h expected 77", rd_data[DBITS +: DBITS]);
        end
    endtask

    task automatic test_random();
        int a0, a1;
        for (int n = 0; n < 400; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            rsv_en   = 1'($urandom_range(0, 2) == 0);
            wr_addr  = ABITS'($urandom_range(0, n[0] ? 31 : 7));
            rsv_addr = ABITS'($urandom_range(0, n[1] ? 31 : 7));
            wr_data  = $urandom;
            a0 = $urandom_range(0, 7);
            a1 = $urandom_range(0, 31);
            if (n % 5 == 0) a0 = int'(wr_addr);
            set_rd(a0, a1);
            #1;
            checks++;
            if (rd_data[0 +: DBITS] !== exp_data(a0) || rd_busy[0] !== exp_busy(a0)) begin
                errors++;
                $display("FAIL rand_p0 n=%0d a=%0d: got %h/%b expected %h/%b", n, a0, rd_data[0 +: DBITS], rd_busy[0], exp_data(a0), exp_busy(a0));
            end
            checks++;
            if (rd_data[DBITS +: DBITS] !== exp_data(a1) || rd_busy[1] !== exp_busy(a1)) begin
                errors++;
                $display("FAIL rand_p1 n=%0d a=%0d: got %h/%b expected %h/%b", n, a1, rd_data[DBITS +: DBITS], rd_busy[1], exp_data(a1), exp_busy(a1));
            end
            checks++;
            if (int'(busy_count) != exp_count()) begin
                errors++;
                $display("FAIL rand_count n=%0d: got %0d expected %0d", n, busy_count, exp_count());
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r < NREG; r++) begin
            wr_en = 1; wr_addr = ABITS'(r); wr_data = 32'h100 + r; cycle();
        end
        rsv_en = 1; rsv_addr = 2; cycle();
        rsv_en = 1; rsv_addr = 4; cycle();
        rsv_en = 1; rsv_addr = 6; cycle();
        #1;
        checks++;
        if (busy_count !== 6'd3) begin
            errors++;
            $display("FAIL three_rsv: got %0d expected 3", busy_count);
        end
        #2 reset = 1;
        #1;
        checks++;
        if (busy_count !== 6'd0) begin
            errors++;
            $display("FAIL midreset_count: got %0d expected 0", busy_count);
        end
        for (int a = 0; a < NREG; a++) begin
            set_rd(a, NREG-1-a);
            #0.1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd_data[p*DBITS +: DBITS] !== '0 || rd_busy[p] !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_read a=%0d p=%0d: got %h/%b expected 0/0", a, p, rd_data[p*DBITS +: DBITS], rd_busy[p]);
                end
            end
        end
        model_clear();
        @(negedge clock); reset = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reserve();
        test_write_reserve_same();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port register file for the MIPS core. It holds the architectural registers with register 0 hard-wired to zero, and adds an optional write-to-read bypass and a per-register busy scoreboard for multi-cycle producers such as loads. It sits between decode (reads, reservations) and writeback (writes), and replaces the fixed 2-read/1-write file.

## Interface
- NREG, 32: number of registers; power of two, at least 2
- DBITS, 32: data width
- NRD, 2: number of read ports, 1..4
- ABITS, $clog2(NREG): address width (derived)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  NRD×ABITS  read addresses, packed; port i is at [i*ABITS +: ABITS]
- rd_data  out  NRD×DBITS  read data, packed the same way
- rd_busy  out  NRD  1 when the addressed register has a reservation outstanding
- wr_en  in  1  writeback enable
- wr_addr  in  ABITS  writeback address
- wr_data  in  DBITS  writeback data
- rsv_en  in  1  reserve a destination (a multi-cycle producer has issued)
- rsv_addr  in  ABITS  register to reserve
- busy_count  out  $clog2(NREG+1)  number of registers currently busy

## Operation
- Storage is NREG×DBITS flops plus a NREG-bit busy vector.
- Reads are combinational.
  - Address 0 always returns 0 with busy 0.
  - Otherwise a read returns the stored value and that register's busy bit.
- Write: when wr_en is 1 and wr_addr is not 0, the register is written on the rising edge and its busy bit is cleared.
- Reserve: when rsv_en is 1 and rsv_addr is not 0, the register's busy bit is set on the rising edge. Data is unchanged.
- Simultaneous write and reserve to the same register: the data is written and busy ends at 1. The reservation belongs to a younger producer, so reserve wins.
- A reserve to an already-busy register is legal and keeps busy at 1. There is no reservation counting.
- A write to a register that is not busy is legal; the busy bit stays 0.
- Writes and reserves to address 0 are discarded with no state change.
- busy_count is the registered population count of the busy vector. It is updated on the same edge as the busy bits, so it always equals the popcount of the current busy vector.

## Timing
- Reset (asynchronous assert) sets all registers to 0, all busy bits to 0 and busy_count to 0.
  - While reset is held, rd_data is 0 and rd_busy is 0 for every address.
- Reset asserted mid-operation discards all reservations immediately, without waiting for a clock edge.
- Read latency is 0 cycles from rd_addr to rd_data/rd_busy.
- Write latency is 1 cycle: the new value is visible on the cycle after the wr_en edge (unless bypass is enabled).
- A reserve is visible on rd_busy from the cycle after the rsv_en edge.
- All ports read the same state in the same cycle. Ports are independent and identical addresses are allowed.

## Configuration
- REGFILE_BYPASS_EN defined: when wr_en is 1 and wr_addr matches a nonzero rd_addr in the same cycle:
  - that port returns wr_data combinationally;
  - rd_busy is 0 for that port, unless rsv_en targets the same register in the same cycle, in which case rd_busy is 1.
- REGFILE_BYPASS_EN undefined: same-cycle reads return the old value and the old busy bit. The writer's value appears on the next cycle.
- The macro has no effect on address 0 or on reset behaviour.

## Structure
- Package regfile_pkg holds:
  - the default constants (NREG_DEF, DBITS_DEF, NRD_DEF);
  - a function popcount_f used for busy_count.
- One sub-module, regfile_read_port, instantiated NRD times through a generate loop. It contains the zero-register mux and the bypass compare for one port.
- The storage, busy vector and busy_count live in the top module.

## Test plan
- Reset, then read all 32 addresses on both ports -> every rd_data is 0 and every rd_busy is 0. Confirm busy_count is 0.
- Write 0xDEADBEEF to r5, then read r5 on the next cycle -> 0xDEADBEEF. Write 0x1234 to r0, then read r0 -> 0, with busy 0.
- Reserve r7 -> rd_busy=1 and busy_count=1. Write 0xA5A5 to r7 -> the next cycle shows rd_busy=0, data 0xA5A5 and busy_count=0.
- In one cycle, write 0x11 to r9 and reserve r9 -> r9 then reads 0x11 with busy=1.
- Same-cycle write of 0x77 to r3 while reading r3 on port 1:
  - with REGFILE_BYPASS_EN, rd_data=0x77;
  - without it, rd_data is the prior value.
- Reserve r2, r4 and r6 (busy_count=3), then assert reset between clock edges -> busy_count, all busy bits and all data clear immediately to 0.
